axil_ram_arbiter: RTL and testbench

Two-requester AXI4-Lite master arbiter that shares a single `axil_ram` slave between two simple request/response clients. It accepts one transaction at a time, runs the full AXI-Lite write (AW+W+B) or read (AR+R) handshake against the RAM, and returns the result to the granted requester as a one-cycle response pulse. It sits between client logic and the `axil_ram` instance, driving its `s_axil_*` ports directly.

---
 rtl/axil_ram_arbiter_if.sv | 39 +++
 rtl/axil_ram_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_axil_ram_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_ram_arbiter_if.sv
// AXI4-Lite bus between axil_ram_arbiter (master side) and an axil_ram slave.
interface axil_ram_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_ram_arbiter.sv
// Two-requester AXI4-Lite master arbiter in front of one axil_ram slave, one transaction at a time.
// Define AXIL_ARB_FIXED_PRIORITY_EN to make requester 0 always win; default is round-robin.
module axil_ram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [STRB_WIDTH-1:0] req0_wstrb,
  output logic                  req0_ready,
  output logic                  resp0_valid,
  output logic [DATA_WIDTH-1:0] resp0_rdata,
  output logic [1:0]            resp0_resp,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [STRB_WIDTH-1:0] req1_wstrb,
  output logic                  req1_ready,
  output logic                  resp1_valid,
  output logic [DATA_WIDTH-1:0] resp1_rdata,
  output logic [1:0]            resp1_resp,
  axil_ram_arbiter_if.master    m_axil
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0]            bresp0_q, bresp0_d, bresp1_q, bresp1_d;
  logic                  win;

`ifdef AXIL_ARB_FIXED_PRIORITY_EN
  always_comb begin
    win = !req0_valid;
  end
`else
  logic prio_q, prio_d;

  // prio_q names the requester that wins a tie; a lone requester always wins.
  always_comb begin
    win = (req0_valid && req1_valid) ? prio_q : req1_valid;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      bresp0_q  <= '0;
      bresp1_q  <= '0;
`ifndef AXIL_ARB_FIXED_PRIORITY_EN
      prio_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      bresp0_q  <= bresp0_d;
      bresp1_q  <= bresp1_d;
`ifndef AXIL_ARB_FIXED_PRIORITY_EN
      prio_q    <= prio_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    bresp0_d  = bresp0_q;
    bresp1_d  = bresp1_q;
`ifndef AXIL_ARB_FIXED_PRIORITY_EN
    prio_d    = prio_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_d   = win;
          addr_d    = win ? req1_addr  : req0_addr;
          wdata_d   = win ? req1_wdata : req0_wdata;
          wstrb_d   = win ? req1_wstrb : req0_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (win ? req1_write : req0_write) ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        // AW and W complete independently; valid is only up while not done.
        aw_done_d = aw_done_q || m_axil.awready;
        w_done_d  = w_done_q  || m_axil.wready;
        if (aw_done_d && w_done_d) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axil.bvalid) begin
          if (grant_q) bresp1_d = m_axil.bresp;
          else         bresp0_d = m_axil.bresp;
          state_d = RESP;
        end
      end
      RD_REQ: begin
        if (m_axil.arready) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_axil.rvalid) begin
          if (grant_q) begin
            rdata1_d = m_axil.rdata;
            bresp1_d = m_axil.rresp;
          end else begin
            rdata0_d = m_axil.rdata;
            bresp0_d = m_axil.rresp;
          end
          state_d = RESP;
        end
      end
      RESP: begin
`ifndef AXIL_ARB_FIXED_PRIORITY_EN
        prio_d  = !grant_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready     = rst && (state_q == IDLE) && req0_valid && !win;
    req1_ready     = rst && (state_q == IDLE) && req1_valid && win;
    resp0_valid    = (state_q == RESP) && !grant_q;
    resp1_valid    = (state_q == RESP) && grant_q;
    resp0_rdata    = rdata0_q;
    resp1_rdata    = rdata1_q;
    resp0_resp     = bresp0_q;
    resp1_resp     = bresp1_q;
    m_axil.awaddr  = addr_q;
    m_axil.awprot  = 3'b000;
    m_axil.awvalid = (state_q == WR_REQ) && !aw_done_q;
    m_axil.wdata   = wdata_q;
    m_axil.wstrb   = wstrb_q;
    m_axil.wvalid  = (state_q == WR_REQ) && !w_done_q;
    m_axil.bready  = (state_q == WR_RESP);
    m_axil.araddr  = addr_q;
    m_axil.arprot  = 3'b000;
    m_axil.arvalid = (state_q == RD_REQ);
    m_axil.rready  = (state_q == RD_DATA);
  end

endmodule

// File: tb/tb_axil_ram_arbiter.sv
// Bench for axil_ram_arbiter: behavioural AXI-Lite RAM slave with stall knobs, scoreboard of responses.
module tb_axil_ram_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          req0_valid, req0_write, req0_ready, resp0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, resp0_rdata;
  logic [SW-1:0] req0_wstrb;
  logic [1:0]    resp0_resp;
  logic          req1_valid, req1_write, req1_ready, resp1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, resp1_rdata;
  logic [SW-1:0] req1_wstrb;
  logic [1:0]    resp1_resp;

  axil_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axil ();

  axil_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb), .req0_ready(req0_ready),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_resp(resp0_resp),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb), .req1_ready(req1_ready),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_resp(resp1_resp),
    .m_axil(axil)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave RAM model ----------------
  logic [DW-1:0] mem [0:7];
  logic [DW-1:0] ref_mem [0:7];
  int unsigned aw_lat = 0, w_lat = 0, aw_cnt, w_cnt;
  bit b_hold = 1'b0;
  logic got_aw, got_w, got_ar;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  int aw_hs = 0, w_hs = 0;

  initial begin
    for (int i = 0; i < 8; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      axil.awready <= 1'b0; axil.wready <= 1'b0; axil.bvalid <= 1'b0; axil.bresp <= 2'b00;
      axil.arready <= 1'b0; axil.rvalid <= 1'b0; axil.rresp <= 2'b00; axil.rdata <= '0;
      got_aw <= 1'b0; got_w <= 1'b0; got_ar <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
    end else begin
      if (axil.awvalid && axil.awready) begin
        axil.awready <= 1'b0; aw_cnt <= 0; got_aw <= 1'b1; wr_addr <= axil.awaddr; aw_hs <= aw_hs + 1;
      end else if (axil.awvalid) begin
        if (aw_cnt >= aw_lat) axil.awready <= 1'b1;
        else aw_cnt <= aw_cnt + 1;
      end
      if (axil.wvalid && axil.wready) begin
        axil.wready <= 1'b0; w_cnt <= 0; got_w <= 1'b1;
        wr_data <= axil.wdata; wr_strb <= axil.wstrb; w_hs <= w_hs + 1;
      end else if (axil.wvalid) begin
        if (w_cnt >= w_lat) axil.wready <= 1'b1;
        else w_cnt <= w_cnt + 1;
      end
      if (got_aw && got_w && !axil.bvalid && !b_hold) begin
        for (int b = 0; b < SW; b++)
          if (wr_strb[b]) mem[wr_addr[4:2]][8*b +: 8] <= wr_data[8*b +: 8];
        axil.bvalid <= 1'b1; axil.bresp <= 2'b00; got_aw <= 1'b0; got_w <= 1'b0;
      end else if (axil.bvalid && axil.bready) begin
        axil.bvalid <= 1'b0;
      end
      if (axil.arvalid && axil.arready) begin
        axil.arready <= 1'b0; got_ar <= 1'b1; rd_addr <= axil.araddr;
      end else if (axil.arvalid && !got_ar) begin
        axil.arready <= 1'b1;
      end
      if (got_ar && !axil.rvalid) begin
        axil.rdata <= mem[rd_addr[4:2]]; axil.rresp <= 2'b00; axil.rvalid <= 1'b1; got_ar <= 1'b0;
      end else if (axil.rvalid && axil.rready) begin
        axil.rvalid <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int            id;
    bit            wr;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  exp_t mon_e;
  int   pulses = 0;

  always @(negedge clk) begin
    if (rst) begin
      check_val("ready_excl", req0_ready & req1_ready, 0);
      if (resp0_valid || resp1_valid) begin
        pulses++;
        check_val("resp_onehot", resp0_valid & resp1_valid, 0);
        if (sb.size() == 0) begin
          check_val("resp_unexpected", {resp1_valid, resp0_valid}, 0);
        end else begin
          mon_e = sb.pop_front();
          check_val("resp_id", resp1_valid, mon_e.id);
          check_val("resp_code", resp1_valid ? resp1_resp : resp0_resp, 0);
          if (!mon_e.wr)
            check_val("resp_rdata", resp1_valid ? resp1_rdata : resp0_rdata, mon_e.rdata);
        end
      end
    end
  end

  task automatic drive(input int id, input bit v, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] s);
    if (id == 0) begin
      req0_valid = v; req0_write = wr; req0_addr = a; req0_wdata = d; req0_wstrb = s;
    end else begin
      req1_valid = v; req1_write = wr; req1_addr = a; req1_wdata = d; req1_wstrb = s;
    end
  endtask

  task automatic issue(input int id, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] s, input bit keep);
    int unsigned cyc = 0;
    bit acc = 1'b0;
    exp_t e;
    drive(id, 1'b1, wr, a, d, s);
    while (!acc && cyc < 200) begin
      @(negedge clk);
      acc = (id == 0) ? req0_ready : req1_ready;
      cyc++;
    end
    check_val("accept", acc, 1);
    if (acc) begin
      if (wr)
        for (int b = 0; b < SW; b++)
          if (s[b]) ref_mem[a[4:2]][8*b +: 8] = d[8*b +: 8];
      e.id = id; e.wr = wr; e.rdata = ref_mem[a[4:2]];
      sb.push_back(e);
      grants.push_back(id);
    end
    @(posedge clk); #1;
    if (!keep) drive(id, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic wait_done();
    int unsigned cyc = 0;
    while (sb.size() != 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check_val("drain", sb.size(), 0);
    sb.delete();
    @(posedge clk); #1;
  endtask

  task automatic check_bus_idle(input string tag);
    check_val({tag, "_awvalid"}, axil.awvalid, 0);
    check_val({tag, "_wvalid"},  axil.wvalid,  0);
    check_val({tag, "_bready"},  axil.bready,  0);
    check_val({tag, "_arvalid"}, axil.arvalid, 0);
    check_val({tag, "_rready"},  axil.rready,  0);
    check_val({tag, "_resp0v"},  resp0_valid,  0);
    check_val({tag, "_resp1v"},  resp1_valid,  0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int a0, w0, p0;
    int unsigned cyc;
    int exp_g [4];

    drive(0, 1'b1, 1'b0, '0, '0, '0);
    drive(1, 1'b1, 1'b0, '0, '0, '0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_ready0", req0_ready, 0);
    check_val("rst_ready1", req1_ready, 0);
    check_bus_idle("rst");
    check_val("rst_rdata0", resp0_rdata, 0);
    check_val("rst_rdata1", resp1_rdata, 0);
    check_val("rst_resp0", resp0_resp, 0);
    check_val("rst_resp1", resp1_resp, 0);
    rst = 1'b1;
    #1;
    check_val("rel_ready0", req0_ready, 1);
    check_val("rel_ready1", req1_ready, 0);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk); #1;

    // single write then read
    issue(0, 1'b1, 5'd4, 32'd2345, 4'hF, 1'b0);
    wait_done();
    check_val("wr_resp0", resp0_resp, 0);
    issue(0, 1'b0, 5'd4, '0, '0, 1'b0);
    wait_done();
    check_val("rd_2345", resp0_rdata, 32'd2345);

    // byte strobes
    issue(0, 1'b1, 5'd12, 32'hAABBCCDD, 4'hF, 1'b0);
    wait_done();
    issue(1, 1'b1, 5'd12, 32'h00000011, 4'h1, 1'b0);
    wait_done();
    issue(1, 1'b0, 5'd12, '0, '0, 1'b0);
    wait_done();
    check_val("strb_rd", resp1_rdata, 32'hAABBCC11);

    // contention from a fresh priority pointer
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    grants.delete();
    fork
      begin
        issue(0, 1'b1, 5'd0, 32'h11, 4'hF, 1'b1);
        issue(0, 1'b1, 5'd0, 32'h11, 4'hF, 1'b0);
      end
      begin
        issue(1, 1'b1, 5'd8, 32'h22, 4'hF, 1'b1);
        issue(1, 1'b1, 5'd8, 32'h22, 4'hF, 1'b0);
      end
    join
    wait_done();
`ifdef AXIL_ARB_FIXED_PRIORITY_EN
    exp_g = '{0, 0, 1, 1};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    check_val("grant_count", grants.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < grants.size()) check_val($sformatf("grant_%0d", i), grants[i], exp_g[i]);
    issue(0, 1'b0, 5'd0, '0, '0, 1'b0);
    wait_done();
    check_val("rb_11", resp0_rdata, 32'h11);
    issue(1, 1'b0, 5'd8, '0, '0, 1'b0);
    wait_done();
    check_val("rb_22", resp1_rdata, 32'h22);

    // handshake skew: W before AW, then AW before W
    aw_lat = 2; w_lat = 0;
    a0 = aw_hs; w0 = w_hs; p0 = pulses;
    issue(0, 1'b1, 5'd16, 32'hCAFE0001, 4'hF, 1'b0);
    wait_done();
    check_val("skew_w_first_aw", aw_hs - a0, 1);
    check_val("skew_w_first_w", w_hs - w0, 1);
    check_val("skew_w_first_pulse", pulses - p0, 1);
    aw_lat = 0; w_lat = 3;
    a0 = aw_hs; w0 = w_hs; p0 = pulses;
    issue(1, 1'b1, 5'd20, 32'hBEEF0002, 4'hF, 1'b0);
    wait_done();
    check_val("skew_aw_first_aw", aw_hs - a0, 1);
    check_val("skew_aw_first_w", w_hs - w0, 1);
    check_val("skew_aw_first_pulse", pulses - p0, 1);
    aw_lat = 0; w_lat = 0;
    issue(0, 1'b0, 5'd16, '0, '0, 1'b0);
    wait_done();
    issue(1, 1'b0, 5'd20, '0, '0, 1'b0);
    wait_done();

    // reset while waiting for B
    b_hold = 1'b1;
    p0 = pulses;
    drive(1, 1'b1, 1'b1, 5'd28, 32'h5555AAAA, 4'hF);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!req1_ready && cyc < 100);
    check_val("midrst_accept", req1_ready, 1);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!axil.bready && cyc < 100);
    check_val("midrst_in_wr_resp", axil.bready, 1);
    rst = 1'b0;
    @(negedge clk);
    check_bus_idle("midrst");
    rst = 1'b1;
    b_hold = 1'b0;
    repeat (3) @(negedge clk);
    check_val("midrst_nopulse", pulses - p0, 0);
    @(posedge clk); #1;
    issue(1, 1'b0, 5'd4, '0, '0, 1'b0);
    wait_done();
    check_val("post_rst_rd", resp1_rdata, 32'd2345);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
